// File: rtl/window_pkg.sv
// Shared types and helpers for the streaming K x K window generator.
package window_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  localparam int unsigned KMin = 3;
  localparam int unsigned KMax = 7;

  // Counter/coordinate width for a range of n values, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned taps(input int unsigned k);
    return k * k;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of storage: synchronous write, asynchronous read at the same address.
module line_buffer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 640
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read returns the pre-write value, so read-modify-write of a column fits one cycle.
  assign rdata = mem[addr];

endmodule

// File: rtl/window_stream_gen.sv
// Streaming K x K neighbourhood generator: raster pixels in, one window per fully
// populated position out, with a single backpressurable output register.
module window_stream_gen
  import window_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned K         = 3,
  parameter int unsigned IMG_W_MAX = 640,
  parameter int unsigned IMG_H_MAX = 480
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [$clog2(IMG_W_MAX+1)-1:0] cfg_width,
  input  logic [$clog2(IMG_H_MAX+1)-1:0] cfg_height,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_W-1:0]              in_pixel,
  output logic                           win_valid,
  input  logic                           win_ready,
  output logic [K*K*DATA_W-1:0]          win_data,
  output logic [$clog2(IMG_H_MAX)-1:0]   win_row,
  output logic [$clog2(IMG_W_MAX)-1:0]   win_col,
  output logic                           win_last,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           cfg_err
);

  localparam int unsigned CWW  = $clog2(IMG_W_MAX + 1);
  localparam int unsigned CHW  = $clog2(IMG_H_MAX + 1);
  localparam int unsigned XW   = $clog2(IMG_W_MAX);
  localparam int unsigned YW   = $clog2(IMG_H_MAX);
  localparam int unsigned KK   = taps(K);
  localparam int unsigned LB   = K - 1;
  localparam int unsigned HALF = (K - 1) / 2;

  state_e state_q, state_d;
  logic [CWW-1:0] cfg_w_q, cfg_w_d;
  logic [CHW-1:0] cfg_h_q, cfg_h_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic [DATA_W-1:0] win_q [K][K];
  logic [DATA_W-1:0] win_d [K][K];

  logic                  win_valid_q, win_valid_d;
  logic [KK*DATA_W-1:0]  win_data_q, win_data_d;
  logic [YW-1:0]         win_row_q, win_row_d;
  logic [XW-1:0]         win_col_q, win_col_d;
  logic                  win_last_q, win_last_d;
  logic                  cfg_err_q, cfg_err_d;

  logic [DATA_W-1:0] lb_rd [LB];
  logic [DATA_W-1:0] lb_wr [LB];
  logic [DATA_W-1:0] new_col [K];

  logic accept, cfg_ok, x_last, y_last, qualifies;

  assign in_ready   = (state_q == StRun) && (!win_valid_q || win_ready);
  assign accept     = in_valid && in_ready;
  assign busy       = (state_q != StIdle);
  assign frame_done = (state_q == StDrain) && win_valid_q && win_ready && win_last_q;

  assign cfg_ok = (32'(cfg_width) >= K) && (32'(cfg_width) <= IMG_W_MAX) &&
                  (32'(cfg_height) >= K) && (32'(cfg_height) <= IMG_H_MAX);
  assign x_last    = (32'(x_q) == 32'(cfg_w_q) - 32'd1);
  assign y_last    = (32'(y_q) == 32'(cfg_h_q) - 32'd1);
  assign qualifies = (32'(x_q) >= K - 1) && (32'(y_q) >= K - 1);

  // lb[j] holds line y-1-j; each accept pushes the column one line further back.
  for (genvar j = 0; j < LB; j++) begin : g_lb
    if (j == 0) begin : g_first
      assign lb_wr[j] = in_pixel;
    end else begin : g_rest
      assign lb_wr[j] = lb_rd[j-1];
    end
    line_buffer #(
      .DATA_W(DATA_W),
      .DEPTH (IMG_W_MAX)
    ) u_line_buffer (
      .clk  (clk),
      .we   (accept),
      .addr (x_q),
      .wdata(lb_wr[j]),
      .rdata(lb_rd[j])
    );
  end

  always_comb begin
    for (int r = 0; r < K - 1; r++) new_col[r] = lb_rd[K-2-r];
    new_col[K-1] = in_pixel;
  end

  always_comb begin
    state_d     = state_q;
    cfg_w_d     = cfg_w_q;
    cfg_h_d     = cfg_h_q;
    x_d         = x_q;
    y_d         = y_q;
    win_d       = win_q;
    win_valid_d = win_valid_q;
    win_data_d  = win_data_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    win_last_d  = win_last_q;
    cfg_err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (cfg_ok) begin
            state_d = StRun;
            cfg_w_d = cfg_width;
            cfg_h_d = cfg_height;
            x_d     = '0;
            y_d     = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (accept && x_last && y_last) state_d = StDrain;
      end
      StDrain: begin
        if (frame_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      if (x_last) begin
        x_d = '0;
        if (!y_last) y_d = y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win_d[r][c] = win_q[r][c+1];
        win_d[r][K-1] = new_col[r];
      end
      win_valid_d = qualifies;
      if (qualifies) begin
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K; c++) win_data_d[(r*K+c)*DATA_W +: DATA_W] = win_d[r][c];
        end
        win_row_d  = YW'(32'(y_q) - HALF);
        win_col_d  = XW'(32'(x_q) - HALF);
        win_last_d = x_last && y_last;
      end
    end else if (win_ready) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cfg_w_q     <= '0;
      cfg_h_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      win_last_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) win_q[r][c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cfg_w_q     <= cfg_w_d;
      cfg_h_q     <= cfg_h_d;
      x_q         <= x_d;
      y_q         <= y_d;
      win_valid_q <= win_valid_d;
      win_data_q  <= win_data_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      win_last_q  <= win_last_d;
      cfg_err_q   <= cfg_err_d;
      win_q       <= win_d;
    end
  end

  assign win_valid = win_valid_q;
  assign win_data  = win_data_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;
  assign win_last  = win_last_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_window_stream_gen.sv
// Scoreboard bench: stimulus pushes expected windows, a negedge monitor pops and compares.
module tb_window_stream_gen;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       win_ready = 1'b1;
  logic [9:0] cfg_width = '0;
  logic [8:0] cfg_height = '0;
  logic [7:0] in_pixel = '0;
  logic       sel5 = 1'b0;
  bit         rnd_rdy = 1'b0;

  logic        ir3, wv3, wl3, b3, fd3, ce3;
  logic [71:0] wd3;
  logic [8:0]  wr3;
  logic [9:0]  wc3;
  logic         ir5, wv5, wl5, b5, fd5, ce5;
  logic [199:0] wd5;
  logic [8:0]   wr5;
  logic [9:0]   wc5;

  logic         m_in_ready, m_valid, m_last, m_busy, m_fd, m_ce;
  logic [199:0] m_data;
  logic [8:0]   m_row;
  logic [9:0]   m_col;

  always #5 clk = ~clk;

  window_stream_gen #(.DATA_W(8), .K(3), .IMG_W_MAX(640), .IMG_H_MAX(480)) dut3 (
    .clk(clk), .reset_n(reset_n), .start(start & ~sel5), .cfg_width(cfg_width),
    .cfg_height(cfg_height), .in_valid(in_valid), .in_ready(ir3), .in_pixel(in_pixel),
    .win_valid(wv3), .win_ready(win_ready), .win_data(wd3), .win_row(wr3), .win_col(wc3),
    .win_last(wl3), .busy(b3), .frame_done(fd3), .cfg_err(ce3)
  );

  window_stream_gen #(.DATA_W(8), .K(5), .IMG_W_MAX(640), .IMG_H_MAX(480)) dut5 (
    .clk(clk), .reset_n(reset_n), .start(start & sel5), .cfg_width(cfg_width),
    .cfg_height(cfg_height), .in_valid(in_valid), .in_ready(ir5), .in_pixel(in_pixel),
    .win_valid(wv5), .win_ready(win_ready), .win_data(wd5), .win_row(wr5), .win_col(wc5),
    .win_last(wl5), .busy(b5), .frame_done(fd5), .cfg_err(ce5)
  );

  assign m_in_ready = sel5 ? ir5 : ir3;
  assign m_valid    = sel5 ? wv5 : wv3;
  assign m_data     = sel5 ? wd5 : {128'b0, wd3};
  assign m_row      = sel5 ? wr5 : wr3;
  assign m_col      = sel5 ? wc5 : wc3;
  assign m_last     = sel5 ? wl5 : wl3;
  assign m_busy     = sel5 ? b5 : b3;
  assign m_fd       = sel5 ? fd5 : fd3;
  assign m_ce       = sel5 ? ce5 : ce3;

  typedef struct packed {
    logic [199:0] d;
    logic [8:0]   r;
    logic [9:0]   c;
    logic         l;
  } exp_t;

  exp_t exq[$];
  int n_cmp = 0, n_bad = 0, n_win = 0, n_fd = 0, n_ce = 0;
  bit hold_vld = 1'b0;
  logic [220:0] hold_snap;

  task automatic chk(input string name, input logic [223:0] act, input logic [223:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (m_fd) n_fd++;
      if (m_ce) n_ce++;
      if (hold_vld) begin
        chk("stall_hold", {m_valid, m_data, m_row, m_col, m_last}, hold_snap);
        hold_vld = 1'b0;
      end
      if (m_valid && !win_ready) begin
        chk("stall_in_ready", m_in_ready, 0);
        hold_snap = {1'b1, m_data, m_row, m_col, m_last};
        hold_vld  = 1'b1;
      end
      if (m_valid && win_ready) begin
        n_win++;
        if (exq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_window: got row %0d col %0d want none", m_row, m_col);
        end else begin
          exp_t e;
          e = exq.pop_front();
          chk("window", {m_data, m_row, m_col, m_last}, {e.d, e.r, e.c, e.l});
        end
      end
    end else begin
      hold_vld = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      win_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic start_frame(input int w, input int h);
    @(posedge clk);
    #1;
    cfg_width  = 10'(w);
    cfg_height = 9'(h);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic push_px(input int y, input int x, input int w, input int h, input int k,
                         input int base);
    int   n = 0;
    exp_t e;
    in_valid = 1'b1;
    in_pixel = 8'(base + y * w + x);
    @(negedge clk);
    while (!m_in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!m_in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_timeout: got 0 want 1 at pixel (%0d,%0d)", y, x);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (y >= k - 1 && x >= k - 1) begin
      e.d = '0;
      for (int r = 0; r < k; r++)
        for (int c = 0; c < k; c++)
          e.d[(r*k+c)*8 +: 8] = 8'(base + (y - k + 1 + r) * w + (x - k + 1 + c));
      e.r = 9'(y - (k - 1) / 2);
      e.c = 10'(x - (k - 1) / 2);
      e.l = (x == w - 1) && (y == h - 1);
      exq.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (m_busy && n < 500) begin
      n++;
      @(negedge clk);
    end
    chk("busy_timeout", m_busy, 0);
  endtask

  task automatic run_frame(input int w, input int h, input int k, input int base,
                           input bit poke);
    int w0 = n_win, f0 = n_fd, c0 = n_ce;
    start_frame(w, h);
    chk("busy_after_start", m_busy, 1);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (poke && y == 1 && x == 2) begin
          cfg_width  = 10'd4;
          cfg_height = 9'd3;
          start      = 1'b1;
          @(posedge clk);
          #1;
          start = 1'b0;
        end
        push_px(y, x, w, h, k, base);
      end
    end
    wait_idle();
    chk("win_count", n_win - w0, (w - k + 1) * (h - k + 1));
    chk("frame_done_count", n_fd - f0, 1);
    chk("queue_empty", exq.size(), 0);
    if (poke) chk("start_ignored", n_ce - c0, 0);
  endtask

  task automatic bad_cfg(input int w, input int h);
    int c0 = n_ce;
    bit bad = 1'b0;
    start_frame(w, h);
    repeat (4) begin
      @(negedge clk);
      if (m_busy || m_in_ready) bad = 1'b1;
    end
    chk("cfg_err_pulse", n_ce - c0, 1);
    chk("cfg_reject_idle", bad, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset3", {ir3, wv3, wd3, wr3, wc3, wl3, b3, fd3, ce3}, 0);
    chk("reset5", {ir5, wv5, wd5, wr5, wc5, wl5, b5, fd5, ce5}, 0);
    reset_n = 1'b1;

    run_frame(5, 4, 3, 0, 1'b0);
    rnd_rdy = 1'b1;
    run_frame(5, 4, 3, 0, 1'b0);
    rnd_rdy = 1'b0;

    bad_cfg(2, 4);
    bad_cfg(5, 481);

    run_frame(5, 4, 3, 50, 1'b1);
    run_frame(4, 3, 3, 100, 1'b0);

    start_frame(5, 4);
    for (int i = 0; i < 9; i++) push_px(i / 5, i % 5, 5, 4, 3, 200);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("reset_midframe", {ir3, wv3, wd3, wr3, wc3, wl3, b3, fd3, ce3}, 0);
    chk("reset_queue_empty", exq.size(), 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_frame(5, 4, 3, 7, 1'b0);

    sel5 = 1'b1;
    run_frame(6, 5, 5, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
